// File: rtl/countdown_timer_pkg.sv
// +------------------------------------------------------------------+
// | counter_pkg - shared state encoding and default widths            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package counter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_EVT_W = 16;
endpackage

`default_nettype wire

// File: rtl/countdown_timer_if.sv
// +------------------------------------------------------------------+
// | countdown_timer_if - control/status bundle of the countdown timer |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface countdown_timer_if #(
  parameter int WIDTH = 32,
  parameter int EVT_W = 16
);
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             resume;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [EVT_W-1:0] evt_cnt;

  modport master (
    output load_val, start, pause, resume, auto_reload,
    input  count, busy, done, evt_cnt
  );

  modport slave (
    input  load_val, start, pause, resume, auto_reload,
    output count, busy, done, evt_cnt
  );
endinterface

`default_nettype wire

// File: rtl/countdown_timer_sat_counter.sv
// +------------------------------------------------------------------+
// | sat_counter - saturating incrementer with synchronous clear       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// +------------------------------------------------------------------+
// | countdown_timer - loadable down-counter, one-shot or periodic     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EVT_W = DEF_EVT_W
) (
  input  logic           clk,
  input  logic           reset,
  countdown_timer_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             evt_clr;
  logic             evt_inc;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    evt_clr  = 1'b0;
    evt_inc  = 1'b0;

    if (bus.start) begin
      reload_d = bus.load_val;
      mode_d   = bus.auto_reload;
      evt_clr  = 1'b1;
      if (bus.load_val != '0) begin
        count_d = bus.load_val;
        state_d = RUN;
      end else begin
        // Zero load expires immediately but is not counted as an event.
        count_d = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (count_q == WIDTH'(1)) begin
            done_d  = 1'b1;
            evt_inc = 1'b1;
            if (mode_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        PAUSED: begin
          if (!bus.pause && bus.resume) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  sat_counter #(
    .W (EVT_W)
  ) u_evt_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (evt_clr),
    .inc   (evt_inc),
    .cnt   (bus.evt_cnt)
  );

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// +------------------------------------------------------------------+
// | tb_countdown_timer - directed bench for countdown_timer           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_countdown_timer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  countdown_timer_if #(.WIDTH(32), .EVT_W(16)) bus ();
  countdown_timer_if #(.WIDTH(32), .EVT_W(4))  bus4 ();

  countdown_timer #(.WIDTH(32), .EVT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  countdown_timer #(.WIDTH(32), .EVT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] c, input logic b,
                           input logic d, input logic [31:0] e);
    check({tag, ".count"}, bus.count, c);
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
    check({tag, ".evt"}, 32'(bus.evt_cnt), e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.load_val = 32'd7;  bus.start = 1'b1; bus.pause = 1'b0;
    bus.resume = 1'b0;     bus.auto_reload = 1'b0;
    bus4.load_val = 32'd0; bus4.start = 1'b0; bus4.pause = 1'b0;
    bus4.resume = 1'b0;    bus4.auto_reload = 1'b0;

    // Reset held with start asserted
    for (int i = 0; i < 10; i++) begin
      step();
      check_all("reset", 32'd0, 1'b0, 1'b0, 32'd0);
    end
    reset = 1'b1;
    bus.start = 1'b0;
    step();
    check_all("idle", 32'd0, 1'b0, 1'b0, 32'd0);

    // One-shot of 5
    bus.load_val = 32'd5; bus.auto_reload = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("os.e0", 32'd5, 1'b1, 1'b0, 32'd0);
    for (int k = 4; k >= 1; k--) begin
      step();
      check_all("os.run", 32'(k), 1'b1, 1'b0, 32'd0);
    end
    step();
    check_all("os.expire", 32'd0, 1'b0, 1'b1, 32'd1);
    step();
    check_all("os.after", 32'd0, 1'b0, 1'b0, 32'd1);

    // Periodic of 3 for 30 cycles
    bus.load_val = 32'd3; bus.auto_reload = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("per.e0", 32'd3, 1'b1, 1'b0, 32'd0);
    for (int i = 1; i <= 30; i++) begin
      step();
      check_all("per.run", (i % 3 == 0) ? 32'd3 : 32'(3 - (i % 3)), 1'b1,
                (i % 3 == 0), 32'(i / 3));
    end

    // Zero load while running
    bus.load_val = 32'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.auto_reload = 1'b0;
    check_all("zero.done", 32'd0, 1'b0, 1'b1, 32'd0);
    step();
    check_all("zero.after", 32'd0, 1'b0, 1'b0, 32'd0);

    // Pause at 6, frozen for 7 edges including the resume edge
    bus.load_val = 32'd10; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("pz.e0", 32'd10, 1'b1, 1'b0, 32'd0);
    for (int k = 9; k >= 6; k--) begin
      step();
      check_all("pz.run", 32'(k), 1'b1, 1'b0, 32'd0);
    end
    bus.pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("pz.held", 32'd6, 1'b1, 1'b0, 32'd0);
    end
    bus.pause = 1'b0; bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    check_all("pz.resume", 32'd6, 1'b1, 1'b0, 32'd0);
    for (int k = 5; k >= 1; k--) begin
      step();
      check_all("pz.run2", 32'(k), 1'b1, 1'b0, 32'd0);
    end
    step();
    check_all("pz.expire", 32'd0, 1'b0, 1'b1, 32'd1);

    // Pause at count 1 suppresses expiry until resumed
    bus.load_val = 32'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check_all("p1.at1", 32'd1, 1'b1, 1'b0, 32'd0);
    bus.pause = 1'b1;
    step();
    check_all("p1.paused", 32'd1, 1'b1, 1'b0, 32'd0);
    bus.resume = 1'b1;
    step();
    check_all("p1.both", 32'd1, 1'b1, 1'b0, 32'd0);
    bus.pause = 1'b0;
    step();
    bus.resume = 1'b0;
    check_all("p1.resume", 32'd1, 1'b1, 1'b0, 32'd0);
    step();
    check_all("p1.expire", 32'd0, 1'b0, 1'b1, 32'd1);

    // Pause and resume ignored in IDLE
    bus.pause = 1'b1; bus.resume = 1'b1;
    step();
    bus.pause = 1'b0; bus.resume = 1'b0;
    check_all("idle.ign", 32'd0, 1'b0, 1'b0, 32'd1);

    // Restart mid-run with 2
    bus.load_val = 32'd8; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 7; k >= 4; k--) begin
      step();
      check_all("rs.run", 32'(k), 1'b1, 1'b0, 32'd0);
    end
    bus.load_val = 32'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("rs.new", 32'd2, 1'b1, 1'b0, 32'd0);
    step();
    check_all("rs.one", 32'd1, 1'b1, 1'b0, 32'd0);
    step();
    check_all("rs.expire", 32'd0, 1'b0, 1'b1, 32'd1);
    step();
    check_all("rs.after", 32'd0, 1'b0, 1'b0, 32'd1);

    // Reset at count 3 aborts silently
    bus.load_val = 32'd5; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check_all("ab.at3", 32'd3, 1'b1, 1'b0, 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_all("ab.reset", 32'd0, 1'b0, 1'b0, 32'd0);
    step();
    check_all("ab.after", 32'd0, 1'b0, 1'b0, 32'd0);

    // Saturation of a 4-bit event counter, periodic load of 1
    bus4.load_val = 32'd1; bus4.auto_reload = 1'b1; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    check("sat.e0.count", bus4.count, 32'd1);
    check("sat.e0.evt", 32'(bus4.evt_cnt), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check("sat.done", 32'(bus4.done), 32'd1);
      check("sat.count", bus4.count, 32'd1);
      check("sat.evt", 32'(bus4.evt_cnt), (i < 15) ? 32'(i) : 32'd15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counting timer: the decrementing, event-producing counterpart to the free-running up-counter.
- Latches a start value and counts down one per clk. Emits a one-cycle done pulse on reaching zero, then stops or auto-reloads.
- Sits beside the up-counter in the counter lab design; its done pulses can drive that counter's clock-enable/event input for cross-checking.

Parameters:
- WIDTH, 32, width of load value and count.
- EVT_W, 16, width of the saturating done-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk; 0 = reset.
- load_val  input  WIDTH  start/reload value, sampled only when start=1.
- start  input  1  load load_val and enter RUN; accepted in any state.
- pause  input  1  RUN -> PAUSED, count held.
- resume  input  1  PAUSED -> RUN.
- auto_reload  input  1  sampled with start; 1 = periodic mode.
- count  output  WIDTH  current remaining count.
- busy  output  1  high in RUN or PAUSED.
- done  output  1  one-cycle pulse when the count expires.
- evt_cnt  output  EVT_W  number of done pulses since reset or start; saturates at all-ones.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, count=0, busy=0, done=0, evt_cnt=0, reload_reg=0, mode_reg=0. Reset overrides all inputs. Reset asserted mid-RUN aborts with no done pulse.
- States: IDLE, RUN, PAUSED. busy = (state != IDLE), registered.
- Input priority per edge: reset > start > pause > resume.
- start=1, any state:
  - reload_reg <= load_val; mode_reg <= auto_reload; evt_cnt <= 0.
  - If load_val != 0: count <= load_val, state <= RUN.
  - If load_val == 0: count <= 0, state <= IDLE, done <= 1 next cycle. Treated as immediate expiry; auto_reload is ignored for a zero value.
- RUN, no start/pause:
  - count > 1: count <= count - 1.
  - count == 1: done <= 1; evt_cnt <= evt_cnt + 1 unless all-ones.
    - mode_reg=1: count <= reload_reg, stay RUN.
    - mode_reg=0: count <= 0, state <= IDLE.
- Latency: start with load_val=N sampled at edge E0. count=N after E0, decrements each edge, reads 1 after edge E(N-1). done=1 and count=0 (one-shot) after edge EN, for exactly one cycle. Periodic mode: done every N cycles, count sequence N..1, N..1, …
- RUN with pause=1: state <= PAUSED; count held; no decrement that edge.
  - pause while count==1: pause wins; no done; expiry occurs after resume.
- PAUSED:
  - count frozen; resume=1 -> RUN; decrement resumes on the following edge.
  - pause and resume both high in PAUSED: stay PAUSED.
- resume in IDLE/RUN, and pause in IDLE/PAUSED: ignored.
- start during RUN/PAUSED: restart with the new value; no done for the aborted run.
- done is registered; it is low in every cycle other than expiry cycles.
- Arithmetic:
  - Unsigned.
  - count never underflows; the count==1 test precedes the decrement.
  - load_val = all-ones is legal (2^WIDTH-1 cycles).
  - evt_cnt saturates, never wraps.

Decomposition:
- Shared package counter_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2).
  - default WIDTH/EVT_W constants.
- One natural sub-module: sat_counter (EVT_W-bit saturating incrementer with sync clear), used for evt_cnt.
- The FSM and down-count stay in the top module.

Test Plan:
- Reset held low 100 ns (10 cycles at 10 ns clk) while start=1 -> count=0, busy=0, done=0, evt_cnt=0 throughout.
- One-shot: start, load_val=5, auto_reload=0 -> count 5,4,3,2,1 then 0. done high exactly one cycle, 5 cycles after start edge; busy falls with done; evt_cnt=1.
- Periodic: load_val=3, auto_reload=1, run 30 cycles -> done every 3rd cycle, count 3,2,1 repeating, evt_cnt=10. start with load_val=0 -> single done next cycle, IDLE, evt_cnt=0.
- Pause/resume: load_val=10, pause at count=6 for 7 cycles, then resume -> count stays 6 while paused. done arrives 7 cycles later than unpaused. pause at count==1 suppresses done until resume.
- Restart/abort: start load_val=8; at count=4 start load_val=2 -> count 2,1, done once, no done for the aborted run. Separately, reset=0 at count=3 -> immediate IDLE, no done.
- Saturation: EVT_W=4, load_val=1, auto_reload=1, 20 cycles -> evt_cnt climbs to 15 and holds; done still pulses every cycle.
